// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    // Address of the first instruction fetched after reset.
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // All-zero word: sll $0,$0,0, the bubble placed in IF/ID on a flush.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Next-PC source selection driven by the D-stage control logic.
    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    // Branch displacement: sign-extended word offset turned into a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC mux; redirects are resolved from the D-stage state.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_F,
    input  logic [31:0] pc_D,
    input  logic [31:0] instr_D,
    input  logic [31:0] jr_target,
    input  npc_sel_e    npc_sel,
    output logic [31:0] npc
);

    logic [31:0] pc_d_plus4;
    logic        unused_opcode_bits;

    assign pc_d_plus4 = pc_D + 32'd4;

    // The opcode field plays no part in target generation.
    assign unused_opcode_bits = ^instr_D[31:26];

    // Select the next fetch address from the four redirect sources.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        npc = pc_F + 32'd4;
        case (npc_sel)
            NPC_PC4: npc = pc_F + 32'd4;
            NPC_BR:  npc = pc_d_plus4 + branch_offset(instr_D[15:0]);
            NPC_J:   npc = {pc_d_plus4[31:28], instr_D[25:0], 2'b00};
            NPC_JR:  npc = jr_target;
            default: npc = pc_F + 32'd4;
        endcase
    end

endmodule : npc_calc

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_D,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] jr_target,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic [31:0] fetch_cnt
);

    logic [31:0] npc;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] if_pc_q,     if_pc_d;
    logic [31:0] if_instr_q,  if_instr_d;
    logic        if_valid_q,  if_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    npc_calc u_npc_calc (
        .pc_F      (pc_q),
        .pc_D      (if_pc_q),
        .instr_D   (if_instr_q),
        .jr_target (jr_target),
        .npc_sel   (npc_sel_e'(npc_sel)),
        .npc       (npc)
    );

    // Next-state: advance on a free cycle; a flush bubbles IF/ID even while stalled.
    always_comb begin
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = if_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        if (!stall) begin
            pc_d    = npc;
            if_pc_d = pc_q;
            if (flush_D) begin
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end else begin
                if_instr_d  = im_rdata;
                if_valid_d  = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end else if (flush_D) begin
            if_instr_d = NOP;
            if_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous return to the reset fetch address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            if_pc_q     <= PC_RESET;
            if_instr_q  <= NOP;
            if_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values.
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign pc_F      = pc_q;
    assign pc_D      = if_pc_q;
    assign instr_D   = if_instr_q;
    assign valid_D   = if_valid_q;
    assign fetch_cnt = fetch_cnt_q;
    assign pc8_D     = if_pc_q + 32'd8;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush_D;
    logic [1:0]  npc_sel;
    logic [31:0] jr_target;
    logic [31:0] im_rdata;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;
    logic [31:0] fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc_f, m_pc_d, m_instr, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush_D   (flush_D),
        .npc_sel   (npc_sel),
        .jr_target (jr_target),
        .im_rdata  (im_rdata),
        .pc_F      (pc_F),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .valid_D   (valid_D),
        .fetch_cnt (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc_f  = 32'h0000_3000;
        m_pc_d  = 32'h0000_3000;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // Target address implied by the selector, computed from the model's D-stage state.
    function automatic logic [31:0] model_npc();
        logic [31:0] seq;
        int          disp;
        seq = m_pc_d + 32'd4;
        case (npc_sel)
            2'd1: begin
                disp = int'($signed(m_instr[15:0])) * 4;
                return seq + 32'(disp);
            end
            2'd2: return (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
            2'd3: return jr_target;
            default: return m_pc_f + 32'd4;
        endcase
    endfunction

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] target;
        if (reset) begin
            model_reset();
        end else if (!stall) begin
            target = model_npc();
            m_pc_d = m_pc_f;
            m_pc_f = target;
            if (flush_D) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_instr = im_rdata;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
        end else if (flush_D) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string where);
        check({where, ".pc_F"},      pc_F,            m_pc_f);
        check({where, ".pc_D"},      pc_D,            m_pc_d);
        check({where, ".instr_D"},   instr_D,         m_instr);
        check({where, ".valid_D"},   {31'd0, valid_D}, {31'd0, m_valid});
        check({where, ".pc8_D"},     pc8_D,           m_pc_d + 32'd8);
        check({where, ".fetch_cnt"}, fetch_cnt,       m_cnt);
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_model(where);
    endtask

    task automatic drive(input logic st, input logic fl, input logic [1:0] sel,
                         input logic [31:0] jr, input logic [31:0] im);
        stall     = st;
        flush_D   = fl;
        npc_sel   = sel;
        jr_target = jr;
        im_rdata  = im;
    endtask

    logic [31:0] held_pc_d;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        check_model("reset");

        // Reset release and sequential fetch
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h3402_0001);
        #1;
        check("release.pc_F", pc_F, 32'h0000_3000);
        step("fetch1");
        check("fetch1.instr_D", instr_D, 32'h3402_0001);
        check("fetch1.pc8_D", pc8_D, 32'h0000_3008);
        check("fetch1.pc_F", pc_F, 32'h0000_3004);
        check("fetch1.cnt", fetch_cnt, 32'd1);

        // Taken branch with imm16 = -1; delay slot enters D
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h1000_FFFF);
        step("beq_in_D");
        check("beq_in_D.pc_D", pc_D, 32'h0000_3004);
        drive(1'b0, 1'b0, 2'd1, 32'h0, 32'h0085_1020);
        step("branch");
        check("branch.pc_F", pc_F, 32'h0000_3004);
        check("branch.slot", instr_D, 32'h0085_1020);
        check("branch.slot_valid", {31'd0, valid_D}, 32'd1);

        // j with target field 0xC10, then jr
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0C00_0C10);
        step("j_in_D");
        drive(1'b0, 1'b0, 2'd2, 32'h0, 32'h0000_0000);
        step("jump");
        check("jump.pc_F", pc_F, 32'h0000_3040);
        drive(1'b0, 1'b0, 2'd3, 32'h0000_3100, 32'h2108_0001);
        step("jr");
        check("jr.pc_F", pc_F, 32'h0000_3100);

        // Three stalled cycles with the selector toggling
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'(i + 1), 32'h0000_7777, 32'hDEAD_0000 + 32'(i));
            step("stall");
            check("stall.pc_F", pc_F, 32'h0000_3100);
        end

        // Flush alone
        drive(1'b0, 1'b1, 2'd0, 32'h0, 32'hAAAA_5555);
        step("flush");
        check("flush.instr_D", instr_D, 32'h0);
        check("flush.pc_F", pc_F, 32'h0000_3104);

        // Flush together with stall
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h2402_0005);
        step("refill");
        held_pc_d = m_pc_d;
        drive(1'b1, 1'b1, 2'd3, 32'h0000_9000, 32'h1234_5678);
        step("flush_stall");
        check("flush_stall.instr_D", instr_D, 32'h0);
        check("flush_stall.pc_F", pc_F, 32'h0000_3108);
        check("flush_stall.pc_D", pc_D, held_pc_d);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFC, 32'h0);
        step("to_top");
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0000_0001);
        step("wrap");
        check("wrap.pc_F", pc_F, 32'h0000_0000);

        // Random traffic, including unaligned jr targets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) == 0), ($urandom_range(6) == 0),
                  2'($urandom_range(3)), $urandom, $urandom);
            step("random");
        end

        // Asynchronous reset mid-stall and mid-redirect at pc_F = 0x3050
        drive(1'b0, 1'b0, 2'd3, 32'h0000_3050, 32'h0);
        step("to_3050");
        check("to_3050.pc_F", pc_F, 32'h0000_3050);
        #2;
        drive(1'b1, 1'b1, 2'd3, 32'h0000_4444, 32'h1111_2222);
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async_reset");
        check("async_reset.pc8_D", pc8_D, 32'h0000_3008);
        step("reset_held");

        // First fetch after the second release
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h3C01_1234);
        step("refetch");
        check("refetch.valid_D", {31'd0, valid_D}, 32'd1);
        check("refetch.pc_D", pc_D, 32'h0000_3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
